// File: rtl/sram_mp_pkg.sv
// sram_mp_pkg
//   Shared types and helpers for the multi-port SRAM model.
//   - sram_state_e : post-reset FSM states (array clear, then serving requests)
//   - RDW_OLD/NEW  : values of the read-during-write mode parameter
//   - lane_merge   : replaces the byte lanes of a word that are selected by a write mask
package sram_mp_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} sram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word lane_merge handles; callers zero-extend into it and truncate the result.
    localparam int MAX_W  = 128;
    localparam int MAX_IW = $clog2(MAX_W);

    // Lane l of the result is new_word's lane l when mask[l] is set, otherwise old_word's.
    function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_word,
                                                    input logic [MAX_W-1:0] new_word,
                                                    input logic [MAX_W-1:0] mask,
                                                    input int               lane_w);
        logic [MAX_W-1:0]  merged;
        logic [MAX_IW-1:0] lane;
        merged = old_word;
        for (int b = 0; b < MAX_W; b++) begin
            lane = MAX_IW'(b / lane_w);
            if (mask[lane]) merged[b] = new_word[b];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_mp_memory_if.sv
// sram_mp_memory_if
//   Per-port request/response bundle of the multi-port SRAM.
//   master (requester): drives ce, we, addr, wmask, wdata;
//                       observes rdata, rvalid, init_done, collision.
//   slave  (memory)   : the mirror image.
interface sram_mp_memory_if #(
    parameter int NUM_PORTS = 2,
    parameter int WIDTH     = 16,
    parameter int AW        = 4,
    parameter int NL        = 2
);
    logic [NUM_PORTS-1:0]            ce;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS-1:0][AW-1:0]    addr;
    logic [NUM_PORTS-1:0][NL-1:0]    wmask;
    logic [NUM_PORTS-1:0][WIDTH-1:0] wdata;
    logic [NUM_PORTS-1:0][WIDTH-1:0] rdata;
    logic [NUM_PORTS-1:0]            rvalid;
    logic                            init_done;
    logic                            collision;

    modport master (output ce, we, addr, wmask, wdata,
                    input  rdata, rvalid, init_done, collision);
    modport slave  (input  ce, we, addr, wmask, wdata,
                    output rdata, rvalid, init_done, collision);
endinterface

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe
//   RD_LAT-deep delay line for one port's read result.
//   in_valid/in_data  : word sampled from the array at the accepting edge
//   out_valid         : pulses RD_LAT cycles after the request cycle
//   out_data          : last delivered result; holds between reads
//   Synchronous reset drops every in-flight result and zeroes the data.
module sram_rd_pipe #(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [RD_LAT-1:0]            valid_q, valid_d;
    logic [RD_LAT-1:0][WIDTH-1:0] data_q,  data_d;

    // A stage only reloads its data when a valid result moves into it, so the
    // last stage keeps the previous result between reads.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        valid_d[0] = in_valid;
        if (in_valid) data_d[0] = in_data;
        for (int s = 1; s < RD_LAT; s++) begin
            valid_d[s] = valid_q[s-1];
            if (valid_q[s-1]) data_d[s] = data_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the values from before this edge, independent of statement order.
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];
endmodule

// File: rtl/sram_mp_memory.sv
// sram_mp_memory
//   Parametrised N-port SRAM with byte-lane writes, a read-latency pipeline and a
//   post-reset clear sequence.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of sram_mp_memory_if
//              ce/we/addr/wmask/wdata per port in; rdata/rvalid per port out;
//              init_done (array ready), collision (same-address multi-port write seen)
//   Same-address writes resolve per lane: the lowest-index port with the lane set wins.
//   RDW_MODE selects whether a read of an address being written sees old or merged data.
module sram_mp_memory
    import sram_mp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int NUM_PORTS  = 2,
    parameter int LANE_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLEAR_INIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_mp_memory_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    sram_state_e     state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            init_done_q, init_done_d;
    logic            collision_q, collision_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0]            wr_en, rd_en;
    logic [NUM_PORTS-1:0][WIDTH-1:0] merged_word, rd_word;
    logic [NUM_PORTS-1:0]            pipe_valid;
    logic [NUM_PORTS-1:0][WIDTH-1:0] pipe_data;

    // Clear sequencer: one zero word per cycle, then ready until the next reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(DEPTH - 1)) state_d = ST_READY;
            end
            ST_READY: state_d = ST_READY;
        endcase
        init_done_d = (state_d == ST_READY);
    end

    // merged_word[p] is the word at port p's address after every write of this
    // cycle. Writers are applied from the highest port down, so the lowest-index
    // port with a lane set is applied last and owns that lane.
    always_comb begin
        wr_en       = '0;
        rd_en       = '0;
        merged_word = '0;
        rd_word     = '0;
        collision_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_en[p] = init_done_q & bus.ce[p] &  bus.we[p];
            rd_en[p] = init_done_q & bus.ce[p] & ~bus.we[p];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            merged_word[p] = mem[bus.addr[p]];
            for (int q = NUM_PORTS - 1; q >= 0; q--) begin
                if (wr_en[q] && bus.addr[q] == bus.addr[p]) begin
                    merged_word[p] = WIDTH'(lane_merge(MAX_W'(merged_word[p]),
                                                       MAX_W'(bus.wdata[q]),
                                                       MAX_W'(bus.wmask[q]), LANE_W));
                end
            end
            rd_word[p] = (RDW_MODE == RDW_NEW) ? merged_word[p] : mem[bus.addr[p]];
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (wr_en[p] && wr_en[q] && bus.addr[p] == bus.addr[q]) collision_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
            collision_q <= collision_d;
        end
    end

    // NOTE: the array has no reset branch; it is zeroed by the clear sequence, which
    // keeps it mappable onto real RAM. Writers sharing an address all store the same
    // merged word, so loop order does not matter here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_addr_q] <= '0;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (wr_en[p]) mem[bus.addr[p]] <= merged_word[p];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_pipe
        sram_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_rd_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (rd_en[p]),
            .in_data   (rd_word[p]),
            .out_valid (pipe_valid[p]),
            .out_data  (pipe_data[p])
        );
    end

    assign bus.rvalid    = pipe_valid;
    assign bus.rdata     = pipe_data;
    assign bus.init_done = init_done_q;
    assign bus.collision = collision_q;
endmodule

// File: tb/tb_sram_mp_memory.sv
// tb_sram_mp_memory
//   Directed bench for sram_mp_memory. Two instances share clk/rst:
//   dut_a: 2 ports, RD_LAT=3, RDW_MODE=0;  dut_b: 4 ports, RD_LAT=1, RDW_MODE=1.
module tb_sram_mp_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [15:0] model_b [16];

    always #5 clk = ~clk;

    sram_mp_memory_if #(.NUM_PORTS(2), .WIDTH(16), .AW(4), .NL(2)) ifa ();
    sram_mp_memory_if #(.NUM_PORTS(4), .WIDTH(16), .AW(4), .NL(2)) ifb ();

    sram_mp_memory #(.WIDTH(16), .DEPTH(16), .NUM_PORTS(2), .LANE_W(8), .RD_LAT(3),
                     .RDW_MODE(0), .CLEAR_INIT(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    sram_mp_memory #(.WIDTH(16), .DEPTH(16), .NUM_PORTS(4), .LANE_W(8), .RD_LAT(1),
                     .RDW_MODE(1), .CLEAR_INIT(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle right after the accepting edge of a dut_a read.
    task automatic a_read_collect(input int p, input logic [15:0] exp, input string tag);
        for (int k = 1; k < 3; k++) begin
            check({tag, "_early"}, ifa.rvalid[p], 1'b0);
            step();
        end
        check({tag, "_rvalid"}, ifa.rvalid[p], 1'b1);
        check({tag, "_data"}, ifa.rdata[p], exp);
        step();
        check({tag, "_pulse"}, ifa.rvalid[p], 1'b0);
        check({tag, "_hold"}, ifa.rdata[p], exp);
    endtask

    task automatic a_read(input int p, input logic [3:0] a, input logic [15:0] exp,
                          input string tag);
        ifa.ce[p]   = 1'b1;
        ifa.we[p]   = 1'b0;
        ifa.addr[p] = a;
        step();
        ifa.ce[p]   = 1'b0;
        a_read_collect(p, exp, tag);
    endtask

    task automatic a_write(input int p, input logic [3:0] a, input logic [1:0] mask,
                           input logic [15:0] data);
        ifa.ce[p]    = 1'b1;
        ifa.we[p]    = 1'b1;
        ifa.addr[p]  = a;
        ifa.wmask[p] = mask;
        ifa.wdata[p] = data;
        step();
        ifa.ce[p]    = 1'b0;
        ifa.we[p]    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  a;
        logic [15:0] w;

        ifa.ce = '0; ifa.we = '0; ifa.addr = '0; ifa.wmask = '0; ifa.wdata = '0;
        ifb.ce = '0; ifb.we = '0; ifb.addr = '0; ifb.wmask = '0; ifb.wdata = '0;

        // Reset state, then init_done rises exactly 16 cycles after rst falls.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_init_a", ifa.init_done, 1'b0);
        check("rst_rvalid_a", ifa.rvalid, 2'b00);
        check("rst_rdata_a", ifa.rdata, 32'h0);
        check("rst_coll_a", ifa.collision, 1'b0);
        check("rst_rvalid_b", ifb.rvalid, 4'h0);
        check("rst_rdata_b", ifb.rdata, 64'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) begin
                check("t1_init_c15_a", ifa.init_done, 1'b0);
                check("t1_init_c15_b", ifb.init_done, 1'b0);
            end
        end
        check("t1_init_c16_a", ifa.init_done, 1'b1);
        check("t1_init_c16_b", ifb.init_done, 1'b1);
        for (int i = 0; i < 16; i++) a_read(i % 2, 4'(i), 16'h0000, $sformatf("t1_zero%0d", i));

        // Read latency 3.
        a_write(0, 4'd5, 2'b11, 16'hBEEF);
        a_read(1, 4'd5, 16'hBEEF, "t2_beef");

        // Overlapping-mask collision: lane0 from port0, lane1 from port1.
        a_write(0, 4'd2, 2'b11, 16'h1234);
        ifa.ce = 2'b11; ifa.we = 2'b11;
        ifa.addr[0] = 4'd2; ifa.wmask[0] = 2'b01; ifa.wdata[0] = 16'hAAAA;
        ifa.addr[1] = 4'd2; ifa.wmask[1] = 2'b11; ifa.wdata[1] = 16'h5555;
        step();
        ifa.ce = '0; ifa.we = '0;
        check("t3_coll_pulse", ifa.collision, 1'b1);
        step();
        check("t3_coll_clear", ifa.collision, 1'b0);
        a_read(0, 4'd2, 16'h55AA, "t3_merge");

        // Disjoint masks to one address still flag a collision.
        ifa.ce = 2'b11; ifa.we = 2'b11;
        ifa.addr[0] = 4'd3; ifa.wmask[0] = 2'b01; ifa.wdata[0] = 16'h1234;
        ifa.addr[1] = 4'd3; ifa.wmask[1] = 2'b10; ifa.wdata[1] = 16'h5678;
        step();
        check("t3_coll_disjoint", ifa.collision, 1'b1);
        ifa.addr[1] = 4'd4; ifa.wmask[1] = 2'b11;
        step();
        ifa.ce = '0; ifa.we = '0;
        check("t3_no_coll_diff_addr", ifa.collision, 1'b0);
        a_read(1, 4'd3, 16'h5634, "t3_disjoint");
        a_read(0, 4'd4, 16'h5678, "t3_addr4");

        // Read-during-write, old-data mode.
        a_write(0, 4'd7, 2'b11, 16'h0001);
        ifa.ce = 2'b11; ifa.we = 2'b01;
        ifa.addr[0] = 4'd7; ifa.wmask[0] = 2'b11; ifa.wdata[0] = 16'h00FF;
        ifa.addr[1] = 4'd7;
        step();
        ifa.ce = '0; ifa.we = '0;
        a_read_collect(1, 16'h0001, "t4_old");
        a_read(0, 4'd7, 16'h00FF, "t4_after");

        // Read-during-write, bypass mode (latency 1).
        ifb.ce = 4'b0001; ifb.we = 4'b0001;
        ifb.addr[0] = 4'd7; ifb.wmask[0] = 2'b11; ifb.wdata[0] = 16'h0001;
        step();
        ifb.ce = 4'b0011; ifb.we = 4'b0001;
        ifb.wdata[0] = 16'h00FF; ifb.addr[1] = 4'd7;
        step();
        ifb.ce = '0; ifb.we = '0;
        check("t4_new_rvalid", ifb.rvalid[1], 1'b1);
        check("t4_new_data", ifb.rdata[1], 16'h00FF);
        // Bypass sees collision resolution: lane0 port0 (AA), lane1 port2 (22).
        ifb.ce = 4'b1101; ifb.we = 4'b0101;
        ifb.addr[0] = 4'd9; ifb.wmask[0] = 2'b01; ifb.wdata[0] = 16'h11AA;
        ifb.addr[2] = 4'd9; ifb.wmask[2] = 2'b11; ifb.wdata[2] = 16'h22BB;
        ifb.addr[3] = 4'd9;
        step();
        ifb.ce = '0; ifb.we = '0;
        check("t4_byp_coll_rvalid", ifb.rvalid[3], 1'b1);
        check("t4_byp_coll_data", ifb.rdata[3], 16'h22AA);
        check("t4_byp_coll_flag", ifb.collision, 1'b1);

        // Reset with a read in flight, then again on clear cycle 8.
        a_write(0, 4'd12, 2'b11, 16'hC0DE);
        ifa.ce[0] = 1'b1; ifa.we[0] = 1'b0; ifa.addr[0] = 4'd12;
        step();
        ifa.ce[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifa.ce[1] = 1'b1; ifa.we[1] = 1'b0; ifa.addr[1] = 4'd5;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5_no_rvalid_c%0d", k), ifa.rvalid, 2'b00);
            check($sformatf("t5_init_low_c%0d", k), ifa.init_done, 1'b0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifa.ce = '0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) check("t5_init_c15", ifa.init_done, 1'b0);
        end
        check("t5_init_c16", ifa.init_done, 1'b1);
        check("t5_rvalid_idle", ifa.rvalid, 2'b00);
        a_read(0, 4'd12, 16'h0000, "t5_clr12");
        a_read(1, 4'd5, 16'h0000, "t5_clr5");

        // Four-port fill, masked and no-op writes, then 32 cycles of 4 reads each.
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) begin
                a = 4'(c * 4 + p);
                w = 16'h3C5A ^ (16'(a) * 16'h1111);
                ifb.ce[p] = 1'b1; ifb.we[p] = 1'b1; ifb.addr[p] = a;
                ifb.wmask[p] = 2'b11; ifb.wdata[p] = w;
                model_b[a] = w;
            end
            step();
            check($sformatf("t6_fill_no_coll%0d", c), ifb.collision, 1'b0);
        end
        ifb.ce = 4'b0110; ifb.we = 4'b0110;
        ifb.addr[1] = 4'd0; ifb.wmask[1] = 2'b10; ifb.wdata[1] = 16'h7EFF;
        ifb.addr[2] = 4'd1; ifb.wmask[2] = 2'b00; ifb.wdata[2] = 16'hFFFF;
        step();
        model_b[0] = 16'h7E5A;
        ifb.we = '0;
        ifb.ce = 4'hF;
        for (int cyc = 0; cyc < 32; cyc++) begin
            for (int p = 0; p < 4; p++) ifb.addr[p] = 4'((cyc + p * 4) % 16);
            step();
            for (int p = 0; p < 4; p++) begin
                check($sformatf("t6_rvalid_c%0d_p%0d", cyc, p), ifb.rvalid[p], 1'b1);
                check($sformatf("t6_data_c%0d_p%0d", cyc, p), ifb.rdata[p],
                      model_b[(cyc + p * 4) % 16]);
            end
        end
        ifb.ce = '0;
        step();
        check("t6_rvalid_idle", ifb.rvalid, 4'h0);
        check("t6_rdata_hold_p0", ifb.rdata[0], model_b[15]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
